// File: rtl/ram_loader_pkg.sv
// Shared types and helpers for the framed-stream RAM loader.
package apple1_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AHI,
        ALO,
        LHI,
        LLO,
        DATA,
        CSUM
    } loader_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Running checksum: XOR of every frame byte after SYNC.
    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/ram_loader.sv
// Frame parser that writes a SYNC/ADDR/LEN/DATA/CSUM byte stream into RAM,
// holding busy for the whole frame and pulsing done or error at its end.
module ram_loader
    import apple1_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_din,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned    TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);

    loader_state_t         state;
    logic [7:0]            addr_hi;
    logic [7:0]            len_hi;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [15:0]           remaining;
    logic [7:0]            csum;
    logic [TW-1:0]         tmo_cnt;
    logic                  accept;

    // No backpressure: every offered byte is taken.
    assign in_ready = 1'b1;
    assign accept   = in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_hi   <= '0;
            len_hi    <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            csum      <= '0;
            tmo_cnt   <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            if (accept) begin
                // An accepted byte always beats a coincident timeout.
                tmo_cnt <= '0;
                unique case (state)
                    IDLE: begin
                        if (in_data == SYNC_BYTE) begin
                            state <= AHI;
                            busy  <= 1'b1;
                            csum  <= '0;
                        end
                    end
                    AHI: begin
                        addr_hi <= in_data;
                        csum    <= csum_fold(csum, in_data);
                        state   <= ALO;
                    end
                    ALO: begin
                        cur_addr <= ADDR_WIDTH'({addr_hi, in_data});
                        csum     <= csum_fold(csum, in_data);
                        state    <= LHI;
                    end
                    LHI: begin
                        len_hi <= in_data;
                        csum   <= csum_fold(csum, in_data);
                        state  <= LLO;
                    end
                    LLO: begin
                        remaining <= {len_hi, in_data};
                        csum      <= csum_fold(csum, in_data);
                        state     <= ({len_hi, in_data} == 16'd0) ? CSUM : DATA;
                    end
                    DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cur_addr;
                        mem_din   <= in_data;
                        cur_addr  <= cur_addr + ADDR_WIDTH'(1);
                        remaining <= remaining - 16'd1;
                        csum      <= csum_fold(csum, in_data);
                        if (remaining == 16'd1) state <= CSUM;
                    end
                    CSUM: begin
                        if (in_data == csum) done <= 1'b1;
                        else                 error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tmo_cnt == TMO_LAST) begin
                    error   <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end

endmodule
